// File: rtl/cam_tag_collector_if.sv
// Tag-beat input and result-readout handshake bundle for the CAM tag collector.
// The subarray/testbench side uses master; the collector uses slave.
interface cam_tag_collector_if #(
  parameter int TAG_W = 16
);
  localparam int IDX_W = $clog2(TAG_W);
  localparam int CNT_W = $clog2(TAG_W + 1);

  logic             tag_valid;
  logic             tag_ready;
  logic [TAG_W-1:0] tag_in;
  logic [1:0]       combine_op;
  logic             tag_last;

  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;
  logic [IDX_W-1:0] res_first_idx;
  logic [CNT_W-1:0] res_count;
  logic             res_trunc;

  modport master (
    output tag_valid, tag_in, combine_op, tag_last, res_ready,
    input  tag_ready, res_valid, res_tag, res_hit, res_first_idx, res_count, res_trunc
  );

  modport slave (
    input  tag_valid, tag_in, combine_op, tag_last, res_ready,
    output tag_ready, res_valid, res_tag, res_hit, res_first_idx, res_count, res_trunc
  );
endinterface

// File: rtl/cam_tag_collector.sv
// Folds groups of CAM search tag beats into one result and queues the result,
// together with its hit/lowest-index/popcount summary, in a small FIFO.
module cam_tag_collector #(
  parameter int TAG_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BEATS  = 8
) (
  input  logic CLK,
  input  logic rst,
  cam_tag_collector_if.slave bus
);
  localparam int IDX_W = $clog2(TAG_W);
  localparam int CNT_W = $clog2(TAG_W + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BC_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int ENT_W = TAG_W + 1 + IDX_W + CNT_W + 1;

  logic [TAG_W-1:0] acc;
  logic             in_group;
  logic [BC_W-1:0]  beat_cnt;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;

  logic             full;
  logic             accept;
  logic             close;
  logic             trunc;
  logic             push;
  logic             pop;
  logic [TAG_W-1:0] acc_next;
  logic [IDX_W-1:0] idx_next;
  logic [CNT_W-1:0] cnt_next;
  logic [ENT_W-1:0] head;

  assign full   = (occ == (PTR_W+1)'(FIFO_DEPTH));
  // Reset dominates: nothing is accepted in a reset cycle.
  assign accept = bus.tag_valid && !full && !rst;
  assign close  = bus.tag_last || (beat_cnt == BC_W'(MAX_BEATS - 1));
  assign trunc  = !bus.tag_last;
  assign push   = accept && close;
  assign pop    = bus.res_valid && bus.res_ready;

  always_comb begin
    acc_next = bus.tag_in;
    if (in_group) begin
      case (bus.combine_op)
        2'b00:   acc_next = bus.tag_in;
        2'b01:   acc_next = acc & bus.tag_in;
        2'b10:   acc_next = acc | bus.tag_in;
        default: acc_next = acc ^ bus.tag_in;
      endcase
    end
  end

  // Scan downward so the lowest set bit wins.
  always_comb begin
    idx_next = '0;
    cnt_next = '0;
    for (int i = TAG_W - 1; i >= 0; i--) begin
      if (acc_next[i]) idx_next = IDX_W'(i);
      cnt_next = cnt_next + CNT_W'(acc_next[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      acc      <= '0;
      in_group <= 1'b0;
      beat_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      if (accept) begin
        if (close) begin
          in_group <= 1'b0;
          beat_cnt <= '0;
        end else begin
          acc      <= acc_next;
          in_group <= 1'b1;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {acc_next, |acc_next, idx_next, cnt_next, trunc};
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign head          = bus.res_valid ? mem[rd_ptr] : '0;
  assign bus.tag_ready = !full;
  assign bus.res_valid = (occ != '0);
  assign {bus.res_tag, bus.res_hit, bus.res_first_idx, bus.res_count, bus.res_trunc} = head;
endmodule

// File: tb/tb_cam_tag_collector.sv
// Directed bench for cam_tag_collector: a beat/expectation table plus
// hand-written backpressure and mid-group reset sequences.
module tb_cam_tag_collector;
  logic CLK = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  cam_tag_collector_if #(.TAG_W(16)) bus ();

  cam_tag_collector #(.TAG_W(16), .FIFO_DEPTH(4), .MAX_BEATS(8)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] tag;
    logic [1:0]  op;
    logic        last;
    logic        ev;
    logic [15:0] et;
    logic        eh;
    logic [3:0]  ei;
    logic [4:0]  ec;
    logic        etr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] tag, input logic [1:0] op, input logic last,
                     input logic ev, input logic [15:0] et, input logic eh,
                     input logic [3:0] ei, input logic [4:0] ec, input logic etr);
    vec_t v;
    v.tag = tag; v.op = op; v.last = last; v.ev = ev;
    v.et = et; v.eh = eh; v.ei = ei; v.ec = ec; v.etr = etr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one beat on the falling edge; it is taken on the following rising edge.
  task automatic beat(input logic [15:0] tag, input logic [1:0] op, input logic last);
    @(negedge CLK);
    chk("tag_ready_before_beat", bus.tag_ready, 1);
    bus.tag_in     = tag;
    bus.combine_op = op;
    bus.tag_last   = last;
    bus.tag_valid  = 1'b1;
    @(posedge CLK);
    #1;
    bus.tag_valid  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    rst            = 1'b1;
    bus.tag_in     = 16'h0001;
    bus.combine_op = 2'b00;
    bus.tag_last   = 1'b1;
    bus.tag_valid  = 1'b1;
    @(posedge CLK);
    #1;
    rst            = 1'b0;
    bus.tag_valid  = 1'b0;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_tag_ready", bus.tag_ready, 1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.tag_valid  = 1'b0;
    bus.tag_in     = '0;
    bus.combine_op = 2'b00;
    bus.tag_last   = 1'b0;
    bus.res_ready  = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_res_valid", bus.res_valid, 0);
    chk("reset_tag_ready", bus.tag_ready, 1);
    chk("reset_res_tag", bus.res_tag, 0);
    chk("reset_res_hit", bus.res_hit, 0);
    chk("reset_res_first_idx", bus.res_first_idx, 0);
    chk("reset_res_count", bus.res_count, 0);
    chk("reset_res_trunc", bus.res_trunc, 0);
    rst = 1'b0;

    add(16'hAAAA, 2'b00, 1, 1, 16'hAAAA, 1, 1, 8, 0);
    add(16'hF0F0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    add(16'hFF00, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    add(16'h000F, 2'b10, 1, 1, 16'hF00F, 1, 0, 8, 0);
    add(16'h00FF, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(16'hFF00, 2'b01, 1, 1, 16'h0000, 0, 0, 0, 0);
    add(16'h8000, 2'b00, 1, 1, 16'h8000, 1, 15, 1, 0);
    add(16'hFFFF, 2'b00, 1, 1, 16'hFFFF, 1, 0, 16, 0);
    add(16'h1234, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(16'h0FF0, 2'b11, 1, 1, 16'h1DC4, 1, 2, 7, 0);
    add(16'h0100, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(16'h0010, 2'b10, 1, 1, 16'h0110, 1, 4, 2, 0);
    add(16'h00F0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(16'h0300, 2'b00, 1, 1, 16'h0300, 1, 8, 2, 0);
    for (int k = 0; k < 7; k++) add(16'h0001, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    add(16'h0001, 2'b11, 0, 1, 16'h0000, 0, 0, 0, 1);
    add(16'h0001, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    add(16'h0000, 2'b10, 1, 1, 16'h0001, 1, 0, 1, 0);
    for (int k = 0; k < 7; k++) add(16'h0002, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    add(16'h0004, 2'b10, 1, 1, 16'h0006, 1, 1, 2, 0);
    add(16'h00F0, 2'b01, 1, 1, 16'h00F0, 1, 4, 4, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      beat(vecs[i].tag, vecs[i].op, vecs[i].last);
      chk($sformatf("v%0d_res_valid", i), bus.res_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_res_tag", i), bus.res_tag, vecs[i].et);
        chk($sformatf("v%0d_res_hit", i), bus.res_hit, vecs[i].eh);
        chk($sformatf("v%0d_res_first_idx", i), bus.res_first_idx, vecs[i].ei);
        chk($sformatf("v%0d_res_count", i), bus.res_count, vecs[i].ec);
        chk($sformatf("v%0d_res_trunc", i), bus.res_trunc, vecs[i].etr);
      end
    end
    @(posedge CLK);
    #1;
    chk("table_drained", bus.res_valid, 0);

    // Backpressure: fill the FIFO with the consumer stalled.
    bus.res_ready = 1'b0;
    beat(16'h0001, 2'b00, 1);
    beat(16'h0002, 2'b00, 1);
    beat(16'h0004, 2'b00, 1);
    beat(16'h0008, 2'b00, 1);
    chk("bp_full_tag_ready", bus.tag_ready, 0);
    chk("bp_head_valid", bus.res_valid, 1);
    chk("bp_head_tag", bus.res_tag, 16'h0001);
    chk("bp_head_idx", bus.res_first_idx, 0);
    @(negedge CLK);
    bus.tag_in     = 16'h0010;
    bus.combine_op = 2'b00;
    bus.tag_last   = 1'b1;
    bus.tag_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk("bp_held_tag_ready", bus.tag_ready, 0);
      chk("bp_held_head_tag", bus.res_tag, 16'h0001);
    end
    bus.res_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.res_ready = 1'b0;
    chk("bp_ready_after_pop", bus.tag_ready, 1);
    chk("bp_head_after_pop", bus.res_tag, 16'h0002);
    @(posedge CLK);
    #1;
    bus.tag_valid = 1'b0;
    chk("bp_fifth_accepted", bus.tag_ready, 0);
    bus.res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] exp_tag;
      exp_tag = 16'h0001 << (k + 1);
      chk("drain_valid", bus.res_valid, 1);
      chk("drain_tag", bus.res_tag, exp_tag);
      chk("drain_idx", bus.res_first_idx, k + 1);
      @(posedge CLK);
      #1;
    end
    chk("drain_empty", bus.res_valid, 0);

    // Reset mid-group: partial group discarded.
    beat(16'h1234, 2'b00, 0);
    beat(16'h5678, 2'b01, 0);
    pulse_reset();
    beat(16'hABCD, 2'b00, 1);
    chk("rmg_valid", bus.res_valid, 1);
    chk("rmg_tag", bus.res_tag, 16'hABCD);
    chk("rmg_count", bus.res_count, 10);
    chk("rmg_idx", bus.res_first_idx, 0);
    chk("rmg_trunc", bus.res_trunc, 0);
    @(posedge CLK);
    #1;
    chk("rmg_popped", bus.res_valid, 0);

    // After reset the next beat must load even when the op says OR.
    beat(16'h1234, 2'b00, 0);
    pulse_reset();
    beat(16'hABCD, 2'b10, 1);
    chk("rmg2_tag", bus.res_tag, 16'hABCD);
    @(posedge CLK);
    #1;
    chk("rmg2_popped", bus.res_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
